// File: rtl/sqrt_fxp_pkg.sv
// sqrt_fxp_pkg
// Shared definitions for the fixed-point square-root unit.
// Contents:
//   IDLE/CALC/DONE  - FSM state encodings (2-bit localparams)
//   calc_n()        - number of root bits, N = (WIDTH+FRAC)/2
//   cnt_width()     - iteration counter width, ceil(log2(N+1))
//   params_ok()     - legality check for WIDTH/FRAC, used at elaboration
package sqrt_fxp_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic int calc_n(input int width, input int frac);
    return (width + frac) / 2;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Both widths must be even so the radicand splits into whole bit pairs.
  // WIDTH >= 4 keeps N >= 2, which the partial-root shift relies on.
  function automatic bit params_ok(input int width, input int frac);
    return (width >= 4) && (width % 2 == 0) && (frac >= 0) &&
           (frac % 2 == 0) && (frac <= width);
  endfunction

endpackage

// File: rtl/sqrt_fxp_if.sv
// sqrt_fxp_if
// Stream bundle around the square-root unit: input stream (s_axis_*) and
// result stream (m_axis_*).
// Parameters: WIDTH (data width), FRAC (fractional bits).
// Modports:
//   slave  - the sqrt unit's view: consumes s_axis_*, produces m_axis_*
//   master - the environment's view: produces s_axis_*, consumes m_axis_*
// Optional build macro: SQRT_FXP_REM_EN adds m_axis_trem (N+1 bits).
interface sqrt_fxp_if #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
);
  import sqrt_fxp_pkg::*;

  logic             s_axis_tvalid;
  logic             s_axis_tready;
  logic [WIDTH-1:0] s_axis_tdata;
  logic             s_axis_tlast;

  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic [WIDTH-1:0] m_axis_tdata;
  logic             m_axis_tlast;
`ifdef SQRT_FXP_REM_EN
  localparam int N = calc_n(WIDTH, FRAC);
  logic [N:0]       m_axis_trem;
`endif

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
`ifdef SQRT_FXP_REM_EN
    , output m_axis_trem
`endif
  );

  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
`ifdef SQRT_FXP_REM_EN
    , input m_axis_trem
`endif
  );

endinterface

// File: rtl/sqrt_fxp_step.sv
// sqrt_fxp_step
// One restoring square-root iteration, purely combinational.
// Ports:
//   ac      in  N+2  current accumulator (partial remainder)
//   q       in  N    current partial root
//   xbits   in  2    next radicand bit pair (MSB pair first)
//   ac_next out N+2  accumulator after this iteration
//   q_next  out N    partial root with the new bit shifted in
module sqrt_fxp_step #(
  parameter int N = 24
) (
  input  logic [N+1:0] ac,
  input  logic [N-1:0] q,
  input  logic [1:0]   xbits,
  output logic [N+1:0] ac_next,
  output logic [N-1:0] q_next
);

  logic [N+1:0] ac_shift;
  logic [N+1:0] trial;
  logic         unused_ac_hi;

  // Before the last iteration the remainder never exceeds N bits, so the
  // top two accumulator bits fall off the shift without losing information.
  assign unused_ac_hi = ^ac[N+1:N];
  assign ac_shift     = {ac[N-1:0], xbits};
  assign trial        = ac_shift - {q, 2'b01};

  // A clear sign bit means the trial subtraction fits: keep it and emit a 1.
  always_comb begin
    if (!trial[N+1]) begin
      ac_next = trial;
      q_next  = {q[N-2:0], 1'b1};
    end else begin
      ac_next = ac_shift;
      q_next  = {q[N-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/sqrt_fxp.sv
// sqrt_fxp
// Streaming fixed-point square root: root = floor(sqrt(tdata * 2^FRAC)),
// one root bit per clock, N = (WIDTH+FRAC)/2 iterations per sample.
// Ports:
//   clk    in  clock
//   reset  in  asynchronous reset, active-low
//   bus    sqrt_fxp_if.slave  (s_axis_* input stream, m_axis_* results)
// Optional build macro: SQRT_FXP_REM_EN builds the remainder register and
// drives m_axis_trem = radicand*2^FRAC - root^2.
module sqrt_fxp
  import sqrt_fxp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic      clk,
  input  logic      reset,
  sqrt_fxp_if.slave bus
);

  localparam int N  = calc_n(WIDTH, FRAC);
  localparam int CW = cnt_width(N);
  localparam int XW = WIDTH + FRAC;

  if (!params_ok(WIDTH, FRAC)) begin : g_param_check
    $error("sqrt_fxp: WIDTH and FRAC must be even with FRAC <= WIDTH");
  end

  logic [1:0]       state;
  logic [XW-1:0]    x;
  logic [N-1:0]     q;
  logic [N+1:0]     ac;
  logic [CW-1:0]    cnt;
  logic             tlast_hold;

  logic             tvalid_r;
  logic [WIDTH-1:0] tdata_r;
  logic             tlast_r;

  logic [N+1:0]     ac_next;
  logic [N-1:0]     q_next;
  logic             s_ready;
  logic             accept;
  logic             last_iter;

  sqrt_fxp_step #(.N(N)) u_step (
    .ac      (ac),
    .q       (q),
    .xbits   (x[XW-1 -: 2]),
    .ac_next (ac_next),
    .q_next  (q_next)
  );

  // In DONE the unit can take a new sample on the same edge that the
  // downstream consumes the result, so there is no bubble between samples.
  assign s_ready   = reset & ((state == IDLE) |
                              ((state == DONE) & bus.m_axis_tready));
  assign accept    = s_ready & bus.s_axis_tvalid;
  assign last_iter = (state == CALC) && (cnt == CW'(1));

  assign bus.s_axis_tready = s_ready;
  assign bus.m_axis_tvalid = tvalid_r;
  assign bus.m_axis_tdata  = tdata_r;
  assign bus.m_axis_tlast  = tlast_r;

  // Control FSM and iteration datapath. A load from IDLE or DONE is written
  // last so it overrides the DONE->IDLE transition when a sample is waiting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      x          <= '0;
      q          <= '0;
      ac         <= '0;
      cnt        <= '0;
      tlast_hold <= 1'b0;
      tvalid_r   <= 1'b0;
      tdata_r    <= '0;
      tlast_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: ;
        CALC: begin
          ac  <= ac_next;
          q   <= q_next;
          x   <= x << 2;
          cnt <= cnt - CW'(1);
          if (last_iter) begin
            tdata_r  <= WIDTH'(q_next);
            tlast_r  <= tlast_hold;
            tvalid_r <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          if (bus.m_axis_tready) begin
            tvalid_r <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        x          <= XW'(bus.s_axis_tdata) << FRAC;
        q          <= '0;
        ac         <= '0;
        cnt        <= CW'(N);
        tlast_hold <= bus.s_axis_tlast;
        state      <= CALC;
      end
    end
  end

`ifdef SQRT_FXP_REM_EN
  logic [N:0] trem_r;

  // The final accumulator is the exact remainder and is at most 2*root,
  // so N+1 bits always hold it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trem_r <= '0;
    end else if (last_iter) begin
      trem_r <= ac_next[N:0];
    end
  end

  assign bus.m_axis_trem = trem_r;
`endif

endmodule

// File: tb/tb_sqrt_fxp.sv
// tb_sqrt_fxp
// Self-checking bench for sqrt_fxp with WIDTH=32, FRAC=16 (N=24).
// Uses a table of known vectors, randomized samples checked against an
// arithmetic square-root model, and hand-written sequences for
// backpressure, back-to-back streaming and reset during a computation.
// Remainder checks are compiled in when SQRT_FXP_REM_EN is defined.
module tb_sqrt_fxp;
  import sqrt_fxp_pkg::*;

  localparam int WIDTH = 32;
  localparam int FRAC  = 16;
  localparam int N     = calc_n(WIDTH, FRAC);

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        last;
    logic [31:0] root;
    logic [31:0] rem;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
    longint      cyc;
  } res_t;

  logic   clk = 1'b0;
  logic   reset;
  int     n_checks = 0;
  int     n_fail   = 0;
  longint cycle    = 0;
  bit     mon_en   = 1'b0;
  res_t   got[$];

  always #5 clk = ~clk;

  sqrt_fxp_if #(.WIDTH(WIDTH), .FRAC(FRAC)) bus ();

  sqrt_fxp #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always @(posedge clk) cycle <= cycle + 1;

  // Collects every completed output handshake while the stream test runs.
  always @(negedge clk) begin
    if (mon_en && bus.m_axis_tvalid && bus.m_axis_tready)
      got.push_back('{data: bus.m_axis_tdata, last: bus.m_axis_tlast, cyc: cycle});
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got %0d cycles, required fewer", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

  // Integer square root of tdata*2^FRAC by binary search on r*r <= v.
  function automatic longint unsigned model_root(input logic [31:0] d);
    longint unsigned v   = longint'(d) << FRAC;
    longint unsigned lo  = 0;
    longint unsigned hi  = (longint'(1) << N) - 1;
    longint unsigned mid;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= v) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  function automatic longint unsigned model_rem(input logic [31:0] d);
    longint unsigned v = longint'(d) << FRAC;
    longint unsigned r = model_root(d);
    return v - r * r;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] data, input logic last);
    int guard = 0;
    @(negedge clk);
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = data;
    bus.s_axis_tlast  = last;
    while (!bus.s_axis_tready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_output("s_ready_wait", bus.s_axis_tready, 1'b1);
    @(posedge clk);
    #1;
    bus.s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_result(output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!bus.m_axis_tvalid && edges < 200);
  endtask

  task automatic run_one(input string name, input logic [31:0] data, input logic last,
                         input logic [31:0] exp_root, input logic [31:0] exp_rem);
    int edges;
    bus.m_axis_tready = 1'b1;
    apply_stimulus(data, last);
    wait_result(edges);
    check_output({name, " latency"}, edges, N);
    check_output({name, " root"}, bus.m_axis_tdata, exp_root);
    check_output({name, " tlast"}, bus.m_axis_tlast, last);
`ifdef SQRT_FXP_REM_EN
    check_output({name, " rem"}, bus.m_axis_trem, exp_rem);
`else
    if (exp_rem > 32'hFFFF_FFFF) $display("[TB] unreachable");
`endif
    @(posedge clk);
    #1;
    check_output({name, " tvalid_drop"}, bus.m_axis_tvalid, 1'b0);
  endtask

  initial begin
    vec_t        vecs[8];
    logic [31:0] d;
    logic [31:0] sdata[8];
    int          edges;
    int          guard;

    vecs[0] = '{"four",     32'h0004_0000, 1'b0, 32'h0002_0000, 32'd0};
    vecs[1] = '{"two",      32'h0002_0000, 1'b1, 32'h0001_6A09, 32'd166831};
    vecs[2] = '{"zero",     32'h0000_0000, 1'b0, 32'h0000_0000, 32'd0};
    vecs[3] = '{"max",      32'hFFFF_FFFF, 1'b1, 32'h00FF_FFFF, 32'h01FE_FFFF};
    vecs[4] = '{"nine",     32'h0009_0000, 1'b0, 32'h0003_0000, 32'd0};
    vecs[5] = '{"one",      32'h0001_0000, 1'b0, 32'h0001_0000, 32'd0};
    vecs[6] = '{"lsb",      32'h0000_0001, 1'b1, 32'h0000_0100, 32'd0};
    vecs[7] = '{"lsb2",     32'h0000_0002, 1'b0, 32'h0000_016A, 32'd28};

    reset             = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tlast  = 1'b0;
    bus.m_axis_tready = 1'b1;

    // Reset state
    #23;
    check_output("reset tvalid", bus.m_axis_tvalid, 1'b0);
    check_output("reset tdata",  bus.m_axis_tdata,  32'h0);
    check_output("reset tlast",  bus.m_axis_tlast,  1'b0);
    check_output("reset s_ready", bus.s_axis_tready, 1'b0);
`ifdef SQRT_FXP_REM_EN
    check_output("reset trem", bus.m_axis_trem, 0);
`endif
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_output("release s_ready", bus.s_axis_tready, 1'b1);

    // Known vectors
    for (int i = 0; i < 8; i++)
      run_one(vecs[i].name, vecs[i].data, vecs[i].last, vecs[i].root, vecs[i].rem);

    // Random samples against the arithmetic model
    for (int i = 0; i < 20; i++) begin
      d = (i % 2 == 0) ? $urandom : $urandom_range(0, 32'h0010_0000);
      run_one("random", d, 1'($urandom_range(0, 1)), 32'(model_root(d)), 32'(model_rem(d)));
    end

    // Backpressure: hold the result for 10 cycles with a sample waiting
    $display("[TB] backpressure sequence");
    bus.m_axis_tready = 1'b0;
    apply_stimulus(32'h0002_0000, 1'b1);
    wait_result(edges);
    check_output("bp latency", edges, N);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = 32'h0009_0000;
        bus.s_axis_tlast  = 1'b0;
      end
      check_output("bp hold tvalid",  bus.m_axis_tvalid, 1'b1);
      check_output("bp hold tdata",   bus.m_axis_tdata,  32'h0001_6A09);
      check_output("bp hold tlast",   bus.m_axis_tlast,  1'b1);
      check_output("bp hold s_ready", bus.s_axis_tready, 1'b0);
`ifdef SQRT_FXP_REM_EN
      check_output("bp hold trem", bus.m_axis_trem, 166831);
`endif
    end
    @(negedge clk);
    bus.m_axis_tready = 1'b1;
    #1;
    check_output("bp s_ready on handshake", bus.s_axis_tready, 1'b1);
    @(posedge clk);
    #1;
    bus.s_axis_tvalid = 1'b0;
    check_output("bp tvalid falls", bus.m_axis_tvalid, 1'b0);
    wait_result(edges);
    check_output("bp next latency", edges, N);
    check_output("bp next root", bus.m_axis_tdata, 32'h0003_0000);
    check_output("bp next tlast", bus.m_axis_tlast, 1'b0);
    @(posedge clk);
    #1;

    // Back-to-back stream of 8 samples, tlast on the last
    $display("[TB] stream sequence");
    got.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sdata[i] = $urandom;
      apply_stimulus(sdata[i], (i == 7));
    end
    guard = 0;
    while (got.size() < 8 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    mon_en = 1'b0;
    check_output("stream count", got.size(), 8);
    for (int i = 0; i < got.size() && i < 8; i++) begin
      check_output("stream root", got[i].data, 32'(model_root(sdata[i])));
      check_output("stream tlast", got[i].last, (i == 7));
      if (i > 0)
        check_output("stream spacing", got[i].cyc - got[i-1].cyc, N + 1);
    end

    // Reset pulse during iteration 10
    $display("[TB] reset-in-calc sequence");
    apply_stimulus(32'h0004_0000, 1'b1);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_output("abort tvalid",  bus.m_axis_tvalid, 1'b0);
    check_output("abort tdata",   bus.m_axis_tdata,  32'h0);
    check_output("abort tlast",   bus.m_axis_tlast,  1'b0);
    check_output("abort s_ready", bus.s_axis_tready, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_output("abort release s_ready", bus.s_axis_tready, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    check_output("abort no stale result", bus.m_axis_tvalid, 1'b0);
    run_one("post_reset", 32'h0009_0000, 1'b0, 32'h0003_0000, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sqrt_fxp.md
# sqrt_fxp

Parametrised fixed-point square-root unit with AXI4-Stream-style handshakes on both sides. Each accepted sample is an unsigned Qm.FRAC radicand; the result is its truncated square root in the same Q format, computed by restoring digit-by-digit iteration at one root bit per clock. The unit sits as a streaming stage in the statistics/mean datapath, between a source that supplies fixed-point values and a downstream consumer. Full backpressure is supported, and an optional remainder output is available.

## Interface
- WIDTH, 32: radicand and root data width in bits. Must be even.
- FRAC, 16: number of fractional bits in the radicand and in the root. Must be even, with FRAC ≤ WIDTH.
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-low.
- s_axis_tvalid  in  1  input sample valid.
- s_axis_tready  out  1  unit can accept a sample.
- s_axis_tdata  in  WIDTH  unsigned radicand, Q(WIDTH−FRAC).FRAC.
- s_axis_tlast  in  1  end-of-packet marker, passed through to the output.
- m_axis_tvalid  out  1  result valid.
- m_axis_tready  in  1  downstream accepts the result.
- m_axis_tdata  out  WIDTH  root in the same Q format, zero-extended.
- m_axis_tlast  out  1  registered copy of s_axis_tlast for this sample.
- m_axis_trem  out  N+1  integer remainder. Present only with SQRT_FXP_REM_EN.

## Operation
- Derived constant: N = (WIDTH+FRAC)/2.
- Computed value: root = floor(sqrt(s_axis_tdata · 2^FRAC)). This is an N-bit integer, zero-extended to WIDTH.
- Internal registers:
  - x: WIDTH+FRAC bits, shift register.
  - q: N bits, partial root.
  - ac: N+2 bits, accumulator.
  - cnt: ceil(log2(N+1)) bits.
- States: IDLE, CALC, DONE.
- IDLE:
  - s_axis_tready = 1.
  - On s_axis_tvalid: load x = {s_axis_tdata, FRAC'b0}, set q = 0, ac = 0, cnt = N, latch tlast, then go to CALC.
- CALC, one iteration per cycle:
  - t = {ac[N−1:0], x[top 2 bits]} − {q, 2'b01}, evaluated at N+2 bits.
  - If t ≥ 0 (MSB clear): ac ← t, q ← {q[N−2:0], 1}.
  - Otherwise: ac ← {ac[N−1:0], x[top 2]}, q ← {q[N−2:0], 0}.
  - Then x ← x << 2 and cnt ← cnt − 1.
  - On the iteration where cnt reaches 0: register m_axis_tdata, m_axis_tlast and m_axis_trem, set m_axis_tvalid = 1, and go to DONE.
- DONE:
  - Output registers are held stable while m_axis_tvalid = 1 and m_axis_tready = 0.
  - On m_axis_tready with s_axis_tvalid: load the new sample directly and go to CALC; m_axis_tvalid falls.
  - On m_axis_tready without s_axis_tvalid: go to IDLE; m_axis_tvalid falls.
- s_axis_tready is combinational: (state == IDLE) | (state == DONE & m_axis_tready). It is forced to 0 while reset is low.
- s_axis_tready is 0 throughout CALC; inputs presented during CALC are ignored.
- tdata = 0 is legal and yields root 0, remainder 0.

## Timing
- Reset values: state = IDLE; m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_trem all 0; internal registers 0.
- Latency: m_axis_tvalid rises exactly N clock edges after the edge at which the sample is accepted. With the defaults, N = 24.
- Throughput: one sample per N+1 cycles when m_axis_tready is held high.
- Reset asserted mid-CALC or in DONE aborts the computation immediately. The in-flight sample is lost and no partial result is emitted.
- Simultaneous output handshake and input acceptance in DONE costs no bubble cycle.

## Configuration
- SQRT_FXP_REM_EN defined:
  - The m_axis_trem port exists.
  - It carries ac at the final iteration, i.e. radicand·2^FRAC − root². This value is ≤ 2·root and fits in N+1 bits.
- SQRT_FXP_REM_EN undefined:
  - The port is absent.
  - The remainder output register is not built.
  - Timing and root are unchanged.

## Structure
- Package sqrt_fxp_pkg holds:
  - the state encodings IDLE/CALC/DONE as localparams;
  - a constant function for N and for the counter width;
  - elaboration checks for even WIDTH/FRAC and FRAC ≤ WIDTH.
- Sub-module sqrt_fxp_step: purely combinational single iteration.
  - Inputs: ac, q, 2 radicand bits.
  - Outputs: next ac, next q.
  - Instantiated once inside the FSM.

## Test plan
All scenarios use the defaults (WIDTH = 32, FRAC = 16).
- 0x00040000 (4.0) → root 0x00020000 (2.0), remainder 0; m_axis_tvalid rises 24 edges after acceptance.
- 0x00020000 (2.0) → root 0x00016A09, remainder 166831 (0x28BAF).
- 0x00000000 → root 0, remainder 0. 0xFFFFFFFF → root 0x00FFFFFF, remainder 0x1FEFFFF.
- Backpressure:
  - Hold m_axis_tready low for 10 cycles after m_axis_tvalid rises.
  - Required: tdata, tlast and trem stay stable, and s_axis_tready = 0.
  - Then raise m_axis_tready with s_axis_tvalid high: the new sample is accepted on the same edge, and the next result appears 24 edges later.
- Back-to-back stream of 8 samples with tlast on the last one, and m_axis_tready held high:
  - results arrive in order, one every 25 cycles;
  - m_axis_tlast = 1 only on the 8th result.
- Reset pulse during CALC (iteration 10):
  - all outputs return to 0 and s_axis_tready rises after reset releases;
  - the next sample 0x00090000 yields 0x00030000.
